// File: rtl/vc_out_arbiter_pkg.sv
// Shared definitions for the VC output scheduler: state encoding, default sizes
// and the helper that maps a destination select onto its pause input.
package vc_out_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SRV0 = 2'd1,
    SRV1 = 2'd2
  } arb_state_e;

  localparam int DATA_WIDTH_DEF = 6;
  localparam int BURST_DEF      = 4;
  localparam int CNT_WIDTH_DEF  = 8;
  localparam int DEST_BIT_DEF   = DATA_WIDTH_DEF - 1;

  function automatic logic destPaused(input logic destSel, input logic pause0,
                                      input logic pause1);
    return destSel ? pause1 : pause0;
  endfunction

endpackage

// File: rtl/vc_out_arbiter_push_counter.sv
// Free-running wrap-around counter of words pushed into one destination FIFO.
module push_counter #(
  parameter int CNT_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 inc_i,
  output logic [CNT_WIDTH-1:0] count_o
);

  logic [CNT_WIDTH-1:0] count_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else if (inc_i) begin
      count_q <= count_q + CNT_WIDTH'(1);
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/vc_out_arbiter.sv
// Pops one of two VC FIFOs per cycle with bounded-burst round-robin fairness and
// per-destination pause, then pushes the registered word to D0 or D1 by its MSB.
module vc_out_arbiter
  import vc_out_arbiter_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int BURST      = BURST_DEF,
  parameter int CNT_WIDTH  = CNT_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  vc0_empty,
  input  logic                  vc1_empty,
  input  logic [DATA_WIDTH-1:0] vc0_data,
  input  logic [DATA_WIDTH-1:0] vc1_data,
  input  logic                  d0_pause,
  input  logic                  d1_pause,
  output logic                  pop_vc0,
  output logic                  pop_vc1,
  output logic                  push_d0,
  output logic                  push_d1,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic [CNT_WIDTH-1:0]  cnt_d0,
  output logic [CNT_WIDTH-1:0]  cnt_d1,
  output logic                  idle
);

  localparam int DEST_BIT = DATA_WIDTH - 1;
  localparam int RUN_W    = $clog2(BURST + 1);
  localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(BURST);
  localparam logic [RUN_W-1:0] RUN_ONE = RUN_W'(1);

  arb_state_e            state_q, state_d;
  logic [RUN_W-1:0]      run_q, run_d;
  logic [DATA_WIDTH-1:0] data_q;
  logic                  pushD0_q, pushD1_q;
  logic                  elig0, elig1;
  logic                  sel0, sel1, popAny;
  logic [DATA_WIDTH-1:0] popWord;

  // A head aimed at a paused destination blocks its own VC only.
  assign elig0 = !vc0_empty && !destPaused(vc0_data[DEST_BIT], d0_pause, d1_pause);
  assign elig1 = !vc1_empty && !destPaused(vc1_data[DEST_BIT], d0_pause, d1_pause);

  always_comb begin
    state_d = state_q;
    run_d   = run_q;
    sel0    = 1'b0;
    sel1    = 1'b0;
    case (state_q)
      IDLE: begin
        if (elig0) begin
          sel0 = 1'b1; state_d = SRV0; run_d = RUN_ONE;
        end else if (elig1) begin
          sel1 = 1'b1; state_d = SRV1; run_d = RUN_ONE;
        end else begin
          run_d = '0;
        end
      end
      SRV0: begin
        // Keep the burst going until BURST, or indefinitely if VC1 has nothing to send.
        if (elig0 && (run_q < RUN_MAX || !elig1)) begin
          sel0  = 1'b1;
          run_d = (run_q == RUN_MAX) ? RUN_MAX : run_q + RUN_ONE;
        end else if (elig1) begin
          sel1 = 1'b1; state_d = SRV1; run_d = RUN_ONE;
        end else begin
          state_d = IDLE; run_d = '0;
        end
      end
      SRV1: begin
        if (elig1 && (run_q < RUN_MAX || !elig0)) begin
          sel1  = 1'b1;
          run_d = (run_q == RUN_MAX) ? RUN_MAX : run_q + RUN_ONE;
        end else if (elig0) begin
          sel0 = 1'b1; state_d = SRV0; run_d = RUN_ONE;
        end else begin
          state_d = IDLE; run_d = '0;
        end
      end
      default: begin
        state_d = IDLE; run_d = '0;
      end
    endcase
  end

  assign popAny  = sel0 || sel1;
  assign popWord = sel1 ? vc1_data : vc0_data;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      run_q    <= '0;
      data_q   <= '0;
      pushD0_q <= 1'b0;
      pushD1_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      run_q    <= run_d;
      pushD0_q <= popAny && !popWord[DEST_BIT];
      pushD1_q <= popAny && popWord[DEST_BIT];
      if (popAny) begin
        data_q <= popWord;
      end
    end
  end

  // Pops are suppressed while reset is held so no word leaves a FIFO unrecorded.
  assign pop_vc0  = sel0 && !reset;
  assign pop_vc1  = sel1 && !reset;
  assign push_d0  = pushD0_q;
  assign push_d1  = pushD1_q;
  assign data_out = data_q;
  assign idle     = (state_q == IDLE);

  push_counter #(.CNT_WIDTH(CNT_WIDTH)) uCntD0 (
    .clk    (clk),
    .reset  (reset),
    .inc_i  (pushD0_q),
    .count_o(cnt_d0)
  );

  push_counter #(.CNT_WIDTH(CNT_WIDTH)) uCntD1 (
    .clk    (clk),
    .reset  (reset),
    .inc_i  (pushD1_q),
    .count_o(cnt_d1)
  );

endmodule

// File: tb/tb_vc_out_arbiter.sv
// Directed bench for vc_out_arbiter: two FIFO models feed the VC inputs and each
// scenario task checks pops, pushes, data and counters against hand-derived values.
module tb_vc_out_arbiter;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       vc0_empty, vc1_empty;
  logic [5:0] vc0_data, vc1_data;
  logic       d0_pause = 1'b0;
  logic       d1_pause = 1'b0;
  logic       pop_vc0, pop_vc1, push_d0, push_d1, idle;
  logic [5:0] data_out;
  logic [7:0] cnt_d0, cnt_d1;

  logic [5:0] mem0 [512];
  logic [5:0] mem1 [512];
  logic [8:0] rd0 = '0, wr0 = '0, rd1 = '0, wr1 = '0;

  int total = 0;
  int bad = 0;
  int exclErr = 0;

  vc_out_arbiter #(.DATA_WIDTH(6), .BURST(4), .CNT_WIDTH(8)) dut (
    .clk      (clk),
    .reset    (reset),
    .vc0_empty(vc0_empty),
    .vc1_empty(vc1_empty),
    .vc0_data (vc0_data),
    .vc1_data (vc1_data),
    .d0_pause (d0_pause),
    .d1_pause (d1_pause),
    .pop_vc0  (pop_vc0),
    .pop_vc1  (pop_vc1),
    .push_d0  (push_d0),
    .push_d1  (push_d1),
    .data_out (data_out),
    .cnt_d0   (cnt_d0),
    .cnt_d1   (cnt_d1),
    .idle     (idle)
  );

  always #5 clk = ~clk;

  assign vc0_empty = (rd0 == wr0);
  assign vc1_empty = (rd1 == wr1);
  assign vc0_data  = mem0[rd0];
  assign vc1_data  = mem1[rd1];

  // First-word-fall-through FIFO models: a pop advances the head on the edge.
  always @(posedge clk) begin
    if (pop_vc0) rd0 <= rd0 + 9'd1;
    if (pop_vc1) rd1 <= rd1 + 9'd1;
  end

  // Exclusivity monitor sampled mid low phase, after inputs have settled.
  always begin
    @(negedge clk);
    #2;
    if (!reset && ((pop_vc0 && pop_vc1) || (push_d0 && push_d1))) exclErr++;
  end

  task automatic loadVc0(input logic [5:0] w);
    mem0[wr0] = w;
    wr0 = wr0 + 9'd1;
  endtask

  task automatic loadVc1(input logic [5:0] w);
    mem1[wr1] = w;
    wr1 = wr1 + 9'd1;
  endtask

  task automatic nextCycle();
    @(negedge clk);
    #1;
  endtask

  task automatic doReset();
    reset = 1'b1;
    #1;
    wr0 = rd0;
    wr1 = rd1;
    d0_pause = 1'b0;
    d1_pause = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    #1;
    total++; if (idle !== 1'b1) begin bad++; $display("[TB] FAIL rst_idle got=%b exp=1", idle); end
    total++; if (push_d0 !== 1'b0 || push_d1 !== 1'b0) begin bad++; $display("[TB] FAIL rst_push got=%b%b exp=00", push_d0, push_d1); end
    total++; if (data_out !== 6'h00) begin bad++; $display("[TB] FAIL rst_data got=%h exp=00", data_out); end
    total++; if (cnt_d0 !== 8'd0 || cnt_d1 !== 8'd0) begin bad++; $display("[TB] FAIL rst_cnt got=%0d/%0d exp=0/0", cnt_d0, cnt_d1); end
    loadVc0(6'h01);
    #1;
    total++; if (pop_vc0 !== 1'b0) begin bad++; $display("[TB] FAIL rst_popgate got=%b exp=0", pop_vc0); end
    doReset();
  endtask

  task automatic test_round_robin();
    logic       expV0, expV1;
    logic [5:0] prevWord;
    int         idx;
    doReset();
    for (int i = 0; i < 8; i++) begin
      loadVc0(6'h01 + 6'(i));
      loadVc1(6'h11 + 6'(i));
    end
    #1;
    prevWord = '0;
    for (int k = 0; k < 17; k++) begin
      expV0 = (k < 16) && (((k / 4) % 2) == 0);
      expV1 = (k < 16) && !expV0;
      total++; if (pop_vc0 !== expV0) begin bad++; $display("[TB] FAIL rr_pop0 k=%0d got=%b exp=%b", k, pop_vc0, expV0); end
      total++; if (pop_vc1 !== expV1) begin bad++; $display("[TB] FAIL rr_pop1 k=%0d got=%b exp=%b", k, pop_vc1, expV1); end
      if (k > 0) begin
        total++; if (push_d0 !== 1'b1 || push_d1 !== 1'b0) begin bad++; $display("[TB] FAIL rr_push k=%0d got=%b%b exp=10", k, push_d0, push_d1); end
        total++; if (data_out !== prevWord) begin bad++; $display("[TB] FAIL rr_data k=%0d got=%h exp=%h", k, data_out, prevWord); end
      end
      if (k == 1) begin
        total++; if (idle !== 1'b0) begin bad++; $display("[TB] FAIL rr_busy got=%b exp=0", idle); end
      end
      idx = (k / 8) * 4 + (k % 4);
      prevWord = expV0 ? 6'h01 + 6'(idx) : 6'h11 + 6'(idx);
      nextCycle();
    end
    total++; if (cnt_d0 !== 8'd16) begin bad++; $display("[TB] FAIL rr_cnt got=%0d exp=16", cnt_d0); end
    total++; if (cnt_d1 !== 8'd0) begin bad++; $display("[TB] FAIL rr_cnt1 got=%0d exp=0", cnt_d1); end
    total++; if (idle !== 1'b1) begin bad++; $display("[TB] FAIL rr_idle got=%b exp=1", idle); end
    total++; if (push_d0 !== 1'b0) begin bad++; $display("[TB] FAIL rr_tail got=%b exp=0", push_d0); end
  endtask

  task automatic test_no_switch();
    doReset();
    for (int i = 0; i < 10; i++) loadVc0(6'h20 + 6'(i));
    #1;
    for (int k = 0; k < 11; k++) begin
      total++; if (pop_vc0 !== (k < 10)) begin bad++; $display("[TB] FAIL ns_pop0 k=%0d got=%b exp=%b", k, pop_vc0, (k < 10)); end
      total++; if (pop_vc1 !== 1'b0) begin bad++; $display("[TB] FAIL ns_pop1 k=%0d got=%b exp=0", k, pop_vc1); end
      if (k > 0) begin
        total++; if (push_d1 !== 1'b1 || data_out !== 6'h20 + 6'(k - 1)) begin bad++; $display("[TB] FAIL ns_push k=%0d got=%b/%h exp=1/%h", k, push_d1, data_out, 6'h20 + 6'(k - 1)); end
      end
      nextCycle();
    end
    total++; if (cnt_d1 !== 8'd10) begin bad++; $display("[TB] FAIL ns_cnt got=%0d exp=10", cnt_d1); end
    total++; if (push_d1 !== 1'b0) begin bad++; $display("[TB] FAIL ns_tail got=%b exp=0", push_d1); end
  endtask

  task automatic test_hol_pause();
    doReset();
    d1_pause = 1'b1;
    loadVc0(6'h21);
    loadVc1(6'h05);
    loadVc1(6'h06);
    #1;
    total++; if (pop_vc0 !== 1'b0 || pop_vc1 !== 1'b1) begin bad++; $display("[TB] FAIL hol_c0 got=%b%b exp=01", pop_vc0, pop_vc1); end
    nextCycle();
    total++; if (pop_vc0 !== 1'b0 || pop_vc1 !== 1'b1) begin bad++; $display("[TB] FAIL hol_c1 got=%b%b exp=01", pop_vc0, pop_vc1); end
    total++; if (push_d0 !== 1'b1 || data_out !== 6'h05) begin bad++; $display("[TB] FAIL hol_push1 got=%b/%h exp=1/05", push_d0, data_out); end
    nextCycle();
    total++; if (pop_vc0 !== 1'b0 || pop_vc1 !== 1'b0) begin bad++; $display("[TB] FAIL hol_blk got=%b%b exp=00", pop_vc0, pop_vc1); end
    total++; if (push_d0 !== 1'b1 || data_out !== 6'h06) begin bad++; $display("[TB] FAIL hol_push2 got=%b/%h exp=1/06", push_d0, data_out); end
    d1_pause = 1'b0;
    #1;
    total++; if (pop_vc0 !== 1'b1) begin bad++; $display("[TB] FAIL hol_release got=%b exp=1", pop_vc0); end
    nextCycle();
    total++; if (push_d1 !== 1'b1 || push_d0 !== 1'b0 || data_out !== 6'h21) begin bad++; $display("[TB] FAIL hol_push3 got=%b%b/%h exp=01/21", push_d0, push_d1, data_out); end
    total++; if (idle !== 1'b0) begin bad++; $display("[TB] FAIL hol_busy got=%b exp=0", idle); end
    nextCycle();
    total++; if (idle !== 1'b1) begin bad++; $display("[TB] FAIL hol_idle got=%b exp=1", idle); end
  endtask

  task automatic test_pause_mid_burst();
    doReset();
    for (int i = 0; i < 6; i++) loadVc0(6'h01 + 6'(i));
    #1;
    for (int k = 0; k < 2; k++) begin
      total++; if (pop_vc0 !== 1'b1) begin bad++; $display("[TB] FAIL pm_pop k=%0d got=%b exp=1", k, pop_vc0); end
      nextCycle();
    end
    d0_pause = 1'b1;
    #1;
    total++; if (pop_vc0 !== 1'b0 || pop_vc1 !== 1'b0) begin bad++; $display("[TB] FAIL pm_stop got=%b%b exp=00", pop_vc0, pop_vc1); end
    total++; if (push_d0 !== 1'b1 || data_out !== 6'h02) begin bad++; $display("[TB] FAIL pm_inflight got=%b/%h exp=1/02", push_d0, data_out); end
    nextCycle();
    total++; if (idle !== 1'b1) begin bad++; $display("[TB] FAIL pm_idle got=%b exp=1", idle); end
    total++; if (push_d0 !== 1'b0) begin bad++; $display("[TB] FAIL pm_nopush got=%b exp=0", push_d0); end
    d0_pause = 1'b0;
    #1;
    total++; if (pop_vc0 !== 1'b1) begin bad++; $display("[TB] FAIL pm_resume got=%b exp=1", pop_vc0); end
    nextCycle();
    total++; if (push_d0 !== 1'b1 || data_out !== 6'h03) begin bad++; $display("[TB] FAIL pm_push got=%b/%h exp=1/03", push_d0, data_out); end
  endtask

  task automatic test_pause_switch();
    doReset();
    d1_pause = 1'b1;
    for (int i = 0; i < 6; i++) loadVc0(6'h01 + 6'(i));
    loadVc1(6'h2A);
    #1;
    for (int k = 0; k < 2; k++) begin
      total++; if (pop_vc0 !== 1'b1 || pop_vc1 !== 1'b0) begin bad++; $display("[TB] FAIL ps_pop k=%0d got=%b%b exp=10", k, pop_vc0, pop_vc1); end
      nextCycle();
    end
    d0_pause = 1'b1;
    d1_pause = 1'b0;
    #1;
    total++; if (pop_vc0 !== 1'b0 || pop_vc1 !== 1'b1) begin bad++; $display("[TB] FAIL ps_switch got=%b%b exp=01", pop_vc0, pop_vc1); end
    nextCycle();
    total++; if (push_d1 !== 1'b1 || push_d0 !== 1'b0 || data_out !== 6'h2A) begin bad++; $display("[TB] FAIL ps_push got=%b%b/%h exp=01/2a", push_d0, push_d1, data_out); end
    total++; if (pop_vc0 !== 1'b0 || pop_vc1 !== 1'b0) begin bad++; $display("[TB] FAIL ps_none got=%b%b exp=00", pop_vc0, pop_vc1); end
    nextCycle();
    total++; if (idle !== 1'b1) begin bad++; $display("[TB] FAIL ps_idle got=%b exp=1", idle); end
  endtask

  task automatic test_reset_mid_burst();
    doReset();
    for (int i = 0; i < 8; i++) loadVc0(6'h01 + 6'(i));
    loadVc1(6'h11);
    loadVc1(6'h12);
    #1;
    for (int k = 0; k < 3; k++) begin
      total++; if (pop_vc0 !== 1'b1) begin bad++; $display("[TB] FAIL rb_pop k=%0d got=%b exp=1", k, pop_vc0); end
      nextCycle();
    end
    total++; if (push_d0 !== 1'b1 || cnt_d0 !== 8'd2) begin bad++; $display("[TB] FAIL rb_pre got=%b/%0d exp=1/2", push_d0, cnt_d0); end
    reset = 1'b1;
    #1;
    total++; if (pop_vc0 !== 1'b0 || pop_vc1 !== 1'b0) begin bad++; $display("[TB] FAIL rb_pop_rst got=%b%b exp=00", pop_vc0, pop_vc1); end
    total++; if (push_d0 !== 1'b0 || data_out !== 6'h00 || cnt_d0 !== 8'd0) begin bad++; $display("[TB] FAIL rb_regs got=%b/%h/%0d exp=0/00/0", push_d0, data_out, cnt_d0); end
    total++; if (idle !== 1'b1) begin bad++; $display("[TB] FAIL rb_idle got=%b exp=1", idle); end
    @(negedge clk);
    reset = 1'b0;
    #1;
    for (int k = 0; k < 5; k++) begin
      total++; if (pop_vc0 !== (k < 4) || pop_vc1 !== (k == 4)) begin bad++; $display("[TB] FAIL rb_after k=%0d got=%b%b exp=%b%b", k, pop_vc0, pop_vc1, (k < 4), (k == 4)); end
      if (k == 1) begin
        total++; if (data_out !== 6'h04) begin bad++; $display("[TB] FAIL rb_data got=%h exp=04", data_out); end
      end
      nextCycle();
    end
  endtask

  task automatic test_wrap();
    doReset();
    for (int i = 0; i < 257; i++) loadVc0(6'h20 | 6'(i % 32));
    #1;
    for (int k = 0; k < 259; k++) begin
      if (k == 256) begin
        total++; if (cnt_d1 !== 8'hFF) begin bad++; $display("[TB] FAIL wr_max got=%0d exp=255", cnt_d1); end
      end
      if (k == 257) begin
        total++; if (cnt_d1 !== 8'h00) begin bad++; $display("[TB] FAIL wr_zero got=%0d exp=0", cnt_d1); end
      end
      nextCycle();
    end
    total++; if (cnt_d1 !== 8'd1) begin bad++; $display("[TB] FAIL wr_cnt got=%0d exp=1", cnt_d1); end
    total++; if (cnt_d0 !== 8'd0) begin bad++; $display("[TB] FAIL wr_cnt0 got=%0d exp=0", cnt_d0); end
    total++; if (pop_vc0 !== 1'b0) begin bad++; $display("[TB] FAIL wr_drained got=%b exp=0", pop_vc0); end
    total++; if (exclErr !== 0) begin bad++; $display("[TB] FAIL excl got=%0d exp=0", exclErr); end
  endtask

  initial begin
    for (int i = 0; i < 512; i++) begin
      mem0[i] = '0;
      mem1[i] = '0;
    end
    test_reset();
    test_round_robin();
    test_no_switch();
    test_hol_pause();
    test_pause_mid_burst();
    test_pause_switch();
    test_reset_mid_burst();
    test_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/vc_out_arbiter.md
# vc_out_arbiter

Output-side scheduler between the two virtual-channel FIFOs (VC0, VC1) and the two destination FIFOs (D0, D1). Each cycle it selects at most one VC FIFO to pop and routes the popped word to the destination named in its MSB. It enforces per-destination pause (almost-full) back-pressure and bounded-burst round-robin fairness between VCs. It is the counterpart of the input flow control that feeds the VC FIFOs from the main FIFO.

## Interface
Parameters:
- DATA_WIDTH, 6, word width; bit DATA_WIDTH-1 is the destination select (0 → D0, 1 → D1)
- BURST, 4, maximum consecutive pops from one VC while the other VC is eligible (≥1)
- CNT_WIDTH, 8, width of per-destination push counters

Ports:
- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-high reset
- vc0_empty  in  1  VC0 FIFO empty
- vc1_empty  in  1  VC1 FIFO empty
- vc0_data  in  DATA_WIDTH  VC0 FIFO head word (first-word-fall-through)
- vc1_data  in  DATA_WIDTH  VC1 FIFO head word (first-word-fall-through)
- d0_pause  in  1  D0 almost-full
- d1_pause  in  1  D1 almost-full
- pop_vc0  out  1  pop VC0 this cycle (combinational)
- pop_vc1  out  1  pop VC1 this cycle (combinational)
- push_d0  out  1  write data_out into D0 (registered)
- push_d1  out  1  write data_out into D1 (registered)
- data_out  out  DATA_WIDTH  registered word for the destinations
- cnt_d0  out  CNT_WIDTH  words pushed to D0 since reset, wraps
- cnt_d1  out  CNT_WIDTH  words pushed to D1 since reset, wraps
- idle  out  1  state is IDLE

## Operation
- Eligibility, combinational: eligX = !vcX_empty && !pause_of(dest(vcX_data)). A VC whose head targets a paused destination is blocked (head-of-line). The other VC may still be served.
- FSM states: IDLE, SRV0, SRV1. Run counter `run` counts 0..BURST and saturates at BURST.
- IDLE:
  - if elig0: pop VC0 → SRV0, run=1
  - else if elig1: pop VC1 → SRV1, run=1
  - else stay in IDLE, run=0
- SRV0:
  - if elig0 && (run<BURST || !elig1): pop VC0, stay, run=min(run+1, BURST)
  - else if elig1: pop VC1 → SRV1, run=1
  - else → IDLE, run=0, no pop
- SRV1: symmetric to SRV0 with the VC roles swapped.
- pop_vc0 and pop_vc1 are never both high. A pop is never issued to an empty FIFO or toward a paused destination.
- Popped word is registered into data_out. Exactly one of push_d0/push_d1 is asserted the following cycle, per the word's MSB.
- cnt_dX increments on every push_dX cycle and wraps from 2^CNT_WIDTH−1 to 0.
- Reset (async, any time, including mid-burst): state=IDLE, run=0, data_out=0, push_d0=push_d1=0, cnt_d0=cnt_d1=0, idle=1. pop_* are 0 while reset is high. A word popped in the cycle reset asserts is dropped; this is accepted.

## Timing
- Pop-to-push latency: 1 cycle. Throughput: 1 word/cycle sustained.
- Pause is sampled in the pop cycle. Destination FIFOs reserve ≥2 entries of almost-full margin to absorb the one in-flight word.
- Pause asserting while a burst is in progress stops pops to that destination in the same cycle.
- Simultaneous eligibility from IDLE: VC0 wins.
- Both VCs become ineligible: → IDLE on the next edge. The next grant from IDLE again prefers VC0.
- idle is driven from registered state.

## Structure
- Shared package holds the state encoding (IDLE=2'd0, SRV0=2'd1, SRV1=2'd2), the DATA_WIDTH/BURST defaults, and a dest-bit index constant, all used by the FIFO and flow-control blocks.
- One natural sub-module, `push_counter` (CNT_WIDTH, inc, wrap, async active-high reset), is instantiated twice for cnt_d0/cnt_d1. FSM, eligibility and datapath register stay in the top.

## Test plan
- Reset mid-burst: 3 VC0 pops into a run, then assert reset → outputs immediately 0, idle=1. After release, pops resume from IDLE with run=1.
- Both VCs full, all words dest D0, no pause → pop sequence VC0×4, VC1×4, VC0×4…. push_d0 follows each pop by one cycle. cnt_d0=16 after 16 pushes.
- VC1 empty, VC0 holds 10 words → 10 consecutive VC0 pops; no switch at BURST because VC1 is not eligible.
- VC0 head dest D1 with d1_pause=1, VC1 head dest D0 → only VC1 popped. Deassert d1_pause → VC0 popped on that same cycle if the arbitration rules select it.
- d0_pause rises during a D0 burst → no pop in that cycle. The FSM moves to the other VC if it is eligible, otherwise to IDLE. No push_d0 two cycles later.
- CNT_WIDTH=8, push 257 words to D1 → cnt_d1 wraps to 1. Across the whole run, pop_vc0&pop_vc1 and push_d0&push_d1 are never both high.
